// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the MEM-stage load/store port.
// It accepts one request at a time and models a RAM with LATENCY cycles of wait states.
// It steers byte, halfword and word lanes and sign- or zero-extends loads.
// It flags misaligned, out-of-range and reserved-size accesses.
// The response is held until the consumer takes it.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   req_valid/ready   request handshake; req_ready is high only when idle
//   req_addr          byte address
//   req_wdata         store data, right-aligned
//   req_we            1 = store, 0 = load
//   req_size          00 word, 01 half, 10 byte, 11 reserved
//   req_unsigned      zero-extend loads
//   req_pc            instruction PC; used only for tracing
//   rsp_valid/ready   response handshake
//   rsp_rdata         extended load data; 0 for stores and errors
//   rsp_err           misaligned, out-of-range or reserved size
//
// Build option: define DMEM_TRACE_EN to $display every committed store.
module dmem_responder #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_pc,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StResp} stateT;

  stateT           stateQ, stateD;
  logic [3:0]      cntQ, cntD;
  logic [XLEN-1:0] addrQ, wdataQ;
  logic            weQ, unsignedQ;
  logic [1:0]      sizeQ;
  logic [XLEN-1:0] mem [DEPTH];

  // Request fields in effect: the live inputs while idle (LATENCY==1 enters RESP on the
  // accept edge itself), otherwise the copy latched at accept.
  logic            isIdle;
  logic [XLEN-1:0] curAddr, curWdata;
  logic            curWe, curUnsigned;
  logic [1:0]      curSize;

  assign isIdle      = (stateQ == StIdle);
  assign curAddr     = isIdle ? req_addr     : addrQ;
  assign curWdata    = isIdle ? req_wdata    : wdataQ;
  assign curWe       = isIdle ? req_we       : weQ;
  assign curSize     = isIdle ? req_size     : sizeQ;
  assign curUnsigned = isIdle ? req_unsigned : unsignedQ;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ <= StIdle;
      cntQ   <= '0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    unique case (stateQ)
      StIdle: begin
        if (req_valid) begin
          cntD   = 4'(LATENCY - 1);
          stateD = (LATENCY == 1) ? StResp : StWait;
        end
      end
      StWait: begin
        if (cntQ == 4'd1) stateD = StResp;
        else              cntD   = cntQ - 4'd1;
      end
      StResp: begin
        if (rsp_ready) stateD = StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    req_ready = (stateQ == StIdle);
    rsp_valid = (stateQ == StResp);
  end

  // Latched request fields; no reset needed, they are only consumed after an accept.
  always_ff @(posedge clk) begin
    if (isIdle && req_valid) begin
      addrQ     <= req_addr;
      wdataQ    <= req_wdata;
      weQ       <= req_we;
      sizeQ     <= req_size;
      unsignedQ <= req_unsigned;
    end
  end

  // ---------------- Datapath ----------------
  logic            enterResp;
  logic [AW-1:0]   wordIdx;
  logic [XLEN-1:0] rdWord, loadData, mergedWord;
  logic            inRange, sizeErr, accErr;
  logic [4:0]      byteSh, halfSh;
  logic [7:0]      byteLane;
  logic [15:0]     halfLane;

  assign enterResp = (stateD == StResp) && (stateQ != StResp);
  assign wordIdx   = curAddr[AW+1:2];
  assign rdWord    = mem[wordIdx];
  assign inRange   = {2'b00, curAddr[XLEN-1:2]} < DEPTH;
  assign byteSh    = {curAddr[1:0], 3'b000};
  assign halfSh    = {curAddr[1], 4'b0000};
  assign byteLane  = 8'(rdWord >> byteSh);
  assign halfLane  = 16'(rdWord >> halfSh);
  assign accErr    = sizeErr || !inRange;

  always_comb begin
    sizeErr = 1'b0;
    case (curSize)
      2'b00:   sizeErr = (curAddr[1:0] != 2'b00);
      2'b01:   sizeErr = curAddr[0];
      2'b10:   sizeErr = 1'b0;
      default: sizeErr = 1'b1;
    endcase
  end

  // Lane extraction for loads and read-modify-write merge for stores.
  always_comb begin
    loadData   = '0;
    mergedWord = rdWord;
    case (curSize)
      2'b00: begin
        loadData   = rdWord;
        mergedWord = curWdata;
      end
      2'b01: begin
        loadData   = {{16{halfLane[15] & ~curUnsigned}}, halfLane};
        mergedWord = (rdWord & ~(32'h0000_ffff << halfSh))
                   | ({16'h0000, curWdata[15:0]} << halfSh);
      end
      2'b10: begin
        loadData   = {{24{byteLane[7] & ~curUnsigned}}, byteLane};
        mergedWord = (rdWord & ~(32'h0000_00ff << byteSh))
                   | ({24'h00_0000, curWdata[7:0]} << byteSh);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (enterResp) begin
      rsp_err   <= accErr;
      rsp_rdata <= (accErr || curWe) ? '0 : loadData;
    end
  end

  // Store commit; a reset on the commit edge drops the request.
  always_ff @(posedge clk) begin
    if (!reset && enterResp && curWe && !accErr) begin
      mem[wordIdx] <= mergedWord;
    end
  end

`ifdef DMEM_TRACE_EN
  logic [XLEN-1:0] pcQ;

  always_ff @(posedge clk) begin
    if (isIdle && req_valid) pcQ <= req_pc;
  end

  always_ff @(posedge clk) begin
    if (!reset && enterResp && curWe && !accErr) begin
      $display("pc = %h: dataaddr = %h, memdata = %h",
               isIdle ? req_pc : pcQ, {curAddr[XLEN-1:2], 2'b00}, mergedWord);
    end
  end
`else
  logic unusedPc;
  assign unusedPc = ^req_pc;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int unsigned DEPTH = 1024;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] reqAddr = '0, reqWdata = '0, reqPc = '0;
  logic        reqWe = 1'b0, reqUnsigned = 1'b0;
  logic [1:0]  reqSize = 2'b00;
  logic        reqValid0 = 1'b0, reqValid1 = 1'b0, rspReady0 = 1'b0, rspReady1 = 1'b0;
  logic        reqReady0, reqReady1, rspValid0, rspValid1, rspErr0, rspErr1;
  logic [31:0] rspRdata0, rspRdata1;

  dmem_responder #(.XLEN(32), .DEPTH(DEPTH), .LATENCY(2)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(reqValid0), .req_ready(reqReady0),
    .req_addr(reqAddr), .req_wdata(reqWdata), .req_we(reqWe), .req_size(reqSize),
    .req_unsigned(reqUnsigned), .req_pc(reqPc),
    .rsp_valid(rspValid0), .rsp_ready(rspReady0), .rsp_rdata(rspRdata0), .rsp_err(rspErr0)
  );

  dmem_responder #(.XLEN(32), .DEPTH(DEPTH), .LATENCY(1)) u_dut_lat1 (
    .clk(clk), .reset(reset),
    .req_valid(reqValid1), .req_ready(reqReady1),
    .req_addr(reqAddr), .req_wdata(reqWdata), .req_we(reqWe), .req_size(reqSize),
    .req_unsigned(reqUnsigned), .req_pc(reqPc),
    .rsp_valid(rspValid1), .rsp_ready(rspReady1), .rsp_rdata(rspRdata1), .rsp_err(rspErr1)
  );

  int nChecks = 0;
  int nPass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) $display("FAIL %s: got %h, want %h", tag, got, exp);
    else             nPass++;
  endtask

  // Reference memory: one byte per address, little-endian, per DUT instance.
  logic [7:0] mdl0 [DEPTH*4];
  logic [7:0] mdl1 [DEPTH*4];

  function automatic logic [7:0] mget(input bit s, input int a);
    return s ? mdl1[a] : mdl0[a];
  endfunction

  task automatic mput(input bit s, input int a, input logic [7:0] b);
    if (s) mdl1[a] = b;
    else   mdl0[a] = b;
  endtask

  // Expected response from the access rules, updating the reference memory on stores.
  task automatic model(input bit s, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] d, output logic e);
    int n;
    logic [31:0] v;
    n = (size == 2'd0) ? 4 : (size == 2'd1) ? 2 : 1;
    e = (size == 2'd3) || (addr % n != 0) || (addr >= DEPTH * 4);
    d = '0;
    if (!e) begin
      if (we) begin
        for (int i = 0; i < n; i++) begin
          v = wdata >> (8 * i);
          mput(s, int'(addr) + i, v[7:0]);
        end
      end else begin
        v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(mget(s, int'(addr) + i)) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hffff_ffff << (8 * n));
        d = v;
      end
    end
  endtask

  function automatic logic curRv(input bit s);
    return s ? rspValid1 : rspValid0;
  endfunction
  function automatic logic curRr(input bit s);
    return s ? reqReady1 : reqReady0;
  endfunction
  function automatic logic [31:0] curData(input bit s);
    return s ? rspRdata1 : rspRdata0;
  endfunction
  function automatic logic curErr(input bit s);
    return s ? rspErr1 : rspErr0;
  endfunction

  // One full transaction: accept, latency, response, optional back-pressure, handshake.
  // Junk (possibly valid) requests are driven while busy and must be ignored.
  task automatic doReq(input bit s, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                       input string tag, output logic [31:0] gotD, output logic gotE);
    logic [31:0] expD;
    logic        expE;
    int          n;
    model(s, we, size, uns, addr, wdata, expD, expE);
    @(negedge clk);
    check({tag, " req_ready idle"}, 32'(curRr(s)), 32'd1);
    reqAddr = addr; reqWdata = wdata; reqWe = we; reqSize = size; reqUnsigned = uns;
    reqPc = $urandom;
    if (s) reqValid1 = 1'b1;
    else   reqValid0 = 1'b1;
    @(posedge clk);
    #1;
    reqAddr = $urandom; reqWdata = $urandom; reqWe = 1'($urandom);
    reqSize = 2'($urandom); reqUnsigned = 1'($urandom);
    reqValid0 = s ? 1'b0 : 1'($urandom);
    reqValid1 = s ? 1'($urandom) : 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!curRv(s) && n < 20);
    check({tag, " latency"}, 32'(n), s ? 32'd1 : 32'd2);
    gotD = curData(s);
    gotE = curErr(s);
    check({tag, " rdata"}, gotD, expD);
    check({tag, " err"}, 32'(gotE), 32'(expE));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({tag, " hold valid"}, 32'(curRv(s)), 32'd1);
      check({tag, " hold rdata"}, curData(s), expD);
      check({tag, " hold req_ready"}, 32'(curRr(s)), 32'd0);
    end
    reqValid0 = 1'b0; reqValid1 = 1'b0;
    if (s) rspReady1 = 1'b1;
    else   rspReady0 = 1'b1;
    @(posedge clk);
    #1;
    rspReady0 = 1'b0; rspReady1 = 1'b0;
    @(negedge clk);
    check({tag, " post valid"}, 32'(curRv(s)), 32'd0);
    check({tag, " post req_ready"}, 32'(curRr(s)), 32'd1);
  endtask

  initial begin
    logic [31:0] d, a;
    logic        e;
    logic [1:0]  sz;
    int          n;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset req_ready", 32'(reqReady0), 32'd1);
    check("reset rsp_valid", 32'(rspValid0), 32'd0);
    check("reset rdata", rspRdata0, 32'd0);
    check("reset err", 32'(rspErr0), 32'd0);

    // Known contents for the regions used below.
    for (int w = 0; w < 256; w++) doReq(0, 1, 2'd0, 0, 32'(w * 4), $urandom, 0, "init0", d, e);
    for (int w = 0; w < 16; w++)  doReq(1, 1, 2'd0, 0, 32'(w * 4), $urandom, 0, "init1", d, e);

    doReq(0, 1, 2'd0, 0, 32'h100, 32'h1234_5678, 0, "sw100", d, e);
    check("sw100 err const", 32'(e), 32'd0);
    doReq(0, 0, 2'd0, 0, 32'h100, 0, 0, "lw100", d, e);
    check("lw100 const", d, 32'h1234_5678);
    doReq(0, 1, 2'd2, 0, 32'h101, 32'h80, 0, "sb101", d, e);
    doReq(0, 0, 2'd2, 0, 32'h101, 0, 0, "lb101", d, e);
    check("lb101 const", d, 32'hffff_ff80);
    doReq(0, 0, 2'd2, 1, 32'h101, 0, 0, "lbu101", d, e);
    check("lbu101 const", d, 32'h0000_0080);
    doReq(0, 0, 2'd0, 0, 32'h100, 0, 0, "lw100b", d, e);
    check("lw100b const", d, 32'h1234_8078);
    doReq(0, 0, 2'd1, 0, 32'h103, 0, 0, "lh103", d, e);
    check("lh103 err const", 32'(e), 32'd1);
    check("lh103 rdata const", d, 32'd0);
    doReq(0, 1, 2'd0, 0, 32'h102, 32'hdead_beef, 0, "sw102", d, e);
    check("sw102 err const", 32'(e), 32'd1);
    doReq(0, 0, 2'd0, 0, 32'h100, 0, 5, "lw100 hold", d, e);
    check("lw100 hold const", d, 32'h1234_8078);

    // Reset on the commit edge of a store: dropped, nothing written.
    @(negedge clk);
    reqAddr = 32'h200; reqWdata = 32'ha5a5_a5a5; reqWe = 1'b1; reqSize = 2'd0;
    reqValid0 = 1'b1;
    @(posedge clk);
    #1 reqValid0 = 1'b0; reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (rspValid0) n++;
    end
    check("rst in wait rsp_valid count", 32'(n), 32'd0);
    check("rst in wait req_ready", 32'(reqReady0), 32'd1);
    doReq(0, 0, 2'd0, 0, 32'h200, 0, 0, "lw200 after rst", d, e);

    doReq(0, 0, 2'd0, 0, 32'h1000, 0, 0, "lw1000", d, e);
    check("lw1000 err const", 32'(e), 32'd1);
    doReq(0, 0, 2'd3, 0, 32'h0, 0, 0, "size11", d, e);
    check("size11 err const", 32'(e), 32'd1);
    check("size11 rdata const", d, 32'd0);

    doReq(1, 1, 2'd0, 0, 32'h10, 32'hcafe_f00d, 0, "l1 sw", d, e);
    doReq(1, 0, 2'd1, 1, 32'h12, 0, 2, "l1 lhu", d, e);
    check("l1 lhu const", d, 32'h0000_cafe);
    doReq(1, 0, 2'd2, 0, 32'h13, 0, 0, "l1 lb", d, e);
    check("l1 lb const", d, 32'hffff_ffca);

    for (int i = 0; i < 300; i++) begin
      a  = ($urandom_range(0, 9) == 0) ? 32'h1000 + 32'($urandom_range(0, 32'h7fff_0000))
                                       : 32'($urandom_range(0, 32'h3ff));
      sz = 2'($urandom_range(0, 3));
      doReq(0, 1'($urandom), sz, 1'($urandom), a, $urandom, $urandom_range(0, 3), "rnd0",
            d, e);
    end
    for (int i = 0; i < 60; i++) begin
      a  = 32'($urandom_range(0, 32'h3f));
      sz = 2'($urandom_range(0, 3));
      doReq(1, 1'($urandom), sz, 1'($urandom), a, $urandom, $urandom_range(0, 2), "rnd1",
            d, e);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
